// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle for seq_shift_add_multiplier.
// Handshake: the host holds M_IN/Q_IN valid on the edge that samples START falling 1->0; AQ is a valid product while READY=1.
interface seq_shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 START;
   logic [WIDTH-1:0]     M_IN;
   logic [WIDTH-1:0]     Q_IN;
   logic                 READY;
   logic [2*WIDTH-1:0]   AQ;

   modport master (
      output START, M_IN, Q_IN,
      input  READY, AQ
   );

   modport slave (
      input  START, M_IN, Q_IN,
      output READY, AQ
   );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier with a combined {A,Q} accumulator register.
// Define SIGNED_MULT_EN for two's-complement operands using radix-2 Booth recoding.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       n_reset,
   seq_shift_add_multiplier_if.slave  bus,
   output logic [1:0]                 state_dbg_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH-1:0]   aq_q, aq_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 ready_q, ready_d;
   logic                 start_prev_q;
   logic                 start_ev;
   logic [WIDTH-1:0]     a_cur;
   logic [WIDTH-1:0]     q_cur;
   // {C,A} after this cycle's add/subtract, before the right shift
   logic [WIDTH:0]       step;
`ifdef SIGNED_MULT_EN
   logic                 qm1_q, qm1_d;
`endif

   assign start_ev = start_prev_q & ~bus.START;
   assign a_cur    = aq_q[2*WIDTH-1:WIDTH];
   assign q_cur    = aq_q[WIDTH-1:0];

`ifdef SIGNED_MULT_EN
   // Sign-extended to WIDTH+1 bits so A-M / A+M never loses the sign before the shift.
   always_comb begin
      case ({q_cur[0], qm1_q})
         2'b10:   step = {a_cur[WIDTH-1], a_cur} - {m_q[WIDTH-1], m_q};
         2'b01:   step = {a_cur[WIDTH-1], a_cur} + {m_q[WIDTH-1], m_q};
         default: step = {a_cur[WIDTH-1], a_cur};
      endcase
   end
`else
   always_comb begin
      if (q_cur[0]) begin
         step = {1'b0, a_cur} + {1'b0, m_q};
      end else begin
         step = {1'b0, a_cur};
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      aq_d    = aq_q;
      count_d = count_q;
      ready_d = ready_q;
`ifdef SIGNED_MULT_EN
      qm1_d   = qm1_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start_ev) begin
               state_d = BUSY;
               m_d     = bus.M_IN;
               aq_d    = {{WIDTH{1'b0}}, bus.Q_IN};
               count_d = CW'(WIDTH);
               ready_d = 1'b0;
`ifdef SIGNED_MULT_EN
               qm1_d   = 1'b0;
`endif
            end
         end
         BUSY: begin
            // The cycle after the last iteration only publishes the result.
            if (count_q == '0) begin
               state_d = DONE;
               ready_d = 1'b1;
            end else begin
               aq_d    = {step, q_cur[WIDTH-1:1]};
               count_d = count_q - CW'(1);
`ifdef SIGNED_MULT_EN
               qm1_d   = q_cur[0];
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= IDLE;
         m_q          <= '0;
         aq_q         <= '0;
         count_q      <= '0;
         ready_q      <= 1'b0;
         start_prev_q <= 1'b1;
`ifdef SIGNED_MULT_EN
         qm1_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         m_q          <= m_d;
         aq_q         <= aq_d;
         count_q      <= count_d;
         ready_q      <= ready_d;
         start_prev_q <= bus.START;
`ifdef SIGNED_MULT_EN
         qm1_q        <= qm1_d;
`endif
      end
   end

   assign bus.READY   = ready_q;
   assign bus.AQ      = aq_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: arithmetic product model plus directed vectors.
// Build with SIGNED_MULT_EN defined to exercise the Booth variant.
module tb_seq_shift_add_multiplier;

   localparam int W   = 8;
   localparam int LAT = W + 1;

   logic          clock   = 1'b0;
   logic          n_reset = 1'b0;
   logic [1:0]    state_dbg;
   int            checks  = 0;
   int            errors  = 0;

   seq_shift_add_multiplier_if #(.WIDTH(W)) bus ();

   seq_shift_add_multiplier #(.WIDTH(W)) dut (
      .clock       (clock),
      .n_reset     (n_reset),
      .bus         (bus),
      .state_dbg_o (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- product model ----------------
   function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] m, input logic [W-1:0] q);
      longint a;
      longint b;
      longint p;
`ifdef SIGNED_MULT_EN
      a = longint'($signed(m));
      b = longint'($signed(q));
`else
      a = longint'(m);
      b = longint'(q);
`endif
      p = a * b;
      return p[2*W-1:0];
   endfunction

   // ---------------- scoreboard / timing model ----------------
   logic [2*W-1:0] exp_q[$];
   logic           m_prev  = 1'b1;
   logic           m_busy  = 1'b0;
   logic           m_ready = 1'b0;
   int             m_cnt   = 0;
   logic [2*W-1:0] m_aq    = '0;

   always @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_prev  = 1'b1;
         m_busy  = 1'b0;
         m_ready = 1'b0;
         m_cnt   = 0;
         m_aq    = '0;
         exp_q.delete();
      end else begin
         if (!m_busy && m_prev && !bus.START) begin
            exp_q.push_back(model_prod(bus.M_IN, bus.Q_IN));
            m_busy  = 1'b1;
            m_ready = 1'b0;
            m_cnt   = LAT;
         end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy  = 1'b0;
               m_ready = 1'b1;
               m_aq    = exp_q.pop_front();
            end
         end
         m_prev = bus.START;
      end
   end

   // Outputs are meaningful every cycle out of reset; AQ only when no operation is running.
   always @(negedge clock) begin
      if (n_reset) begin
         checks++;
         if (bus.READY !== m_ready) begin
            errors++;
            $display("FAIL ready_track: got %b expected %b at %0t", bus.READY, m_ready, $time);
         end
         if (!m_busy) begin
            checks++;
            if (bus.AQ !== m_aq) begin
               errors++;
               $display("FAIL aq_track: got %h expected %h at %0t", bus.AQ, m_aq, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int hold,
                         input bit glitch, input logic [2*W-1:0] exp_lit, input string name);
      int n;
      check({name, "_model"}, 32'(model_prod(m, q)), 32'(exp_lit));
      @(negedge clock);
      bus.M_IN  = m;
      bus.Q_IN  = q;
      bus.START = 1'b0;
      @(posedge clock);
      #1;
      check({name, "_ready_drop"}, 32'(bus.READY), 32'd0);
      bus.M_IN = ~m;
      bus.Q_IN = q ^ 8'h5A;
      n = 0;
      while (n < 20 && bus.READY !== 1'b1) begin
         @(posedge clock);
         #1;
         n++;
         if (n >= hold) bus.START = 1'b1;
         if (glitch && n == 3) bus.START = 1'b0;
         if (glitch && n == 4) bus.START = 1'b1;
      end
      check({name, "_latency"}, 32'(n), 32'(LAT));
      check({name, "_aq"}, 32'(bus.AQ), 32'(exp_lit));
      while (n < hold) begin
         @(posedge clock);
         #1;
         n++;
      end
      bus.START = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check({name, "_hold_ready"}, 32'(bus.READY), 32'd1);
      check({name, "_hold_aq"}, 32'(bus.AQ), 32'(exp_lit));
   endtask

   task automatic reset_mid_op(input logic [W-1:0] m, input logic [W-1:0] q);
      @(negedge clock);
      bus.M_IN  = m;
      bus.Q_IN  = q;
      bus.START = 1'b0;
      @(posedge clock);
      #1;
      bus.START = 1'b1;
      repeat (3) @(posedge clock);
      #3;
      n_reset = 1'b0;
      #1;
      check("rst_mid_ready", 32'(bus.READY), 32'd0);
      check("rst_mid_aq", 32'(bus.AQ), 32'd0);
      repeat (2) @(negedge clock);
      n_reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   // ---------------- directed vectors ----------------
`ifdef SIGNED_MULT_EN
   localparam logic [W-1:0]   VM[4] = '{8'd13, 8'hFD, 8'h80, 8'h7F};
   localparam logic [W-1:0]   VQ[4] = '{8'd11, 8'd5,  8'h80, 8'hFF};
   localparam logic [2*W-1:0] VP[4] = '{16'h008F, 16'hFFF1, 16'h4000, 16'hFF81};
   localparam logic [2*W-1:0] POST_RST_EXP = 16'hEA20;
`else
   localparam logic [W-1:0]   VM[4] = '{8'd13, 8'd255, 8'd0,  8'd20};
   localparam logic [W-1:0]   VQ[4] = '{8'd11, 8'd255, 8'hA5, 8'd30};
   localparam logic [2*W-1:0] VP[4] = '{16'h008F, 16'hFE01, 16'h0000, 16'h0258};
   localparam logic [2*W-1:0] POST_RST_EXP = 16'h4E20;
`endif

   initial begin
      bus.START = 1'b1;
      bus.M_IN  = '0;
      bus.Q_IN  = '0;
      n_reset   = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_ready", 32'(bus.READY), 32'd0);
      check("reset_aq", 32'(bus.AQ), 32'd0);
      n_reset = 1'b1;
      repeat (6) @(negedge clock);
      check("idle_ready", 32'(bus.READY), 32'd0);
      check("idle_aq", 32'(bus.AQ), 32'd0);

      for (int i = 0; i < 4; i++) begin
         run_op(VM[i], VQ[i], 1, 1'b0, VP[i], $sformatf("vec%0d", i));
      end

      run_op(8'd7, 8'd9, 14, 1'b0, 16'h003F, "held_low");
      run_op(8'd20, 8'd30, 1, 1'b1, 16'h0258, "busy_glitch");

      reset_mid_op(8'd50, 8'd60);
      run_op(8'd100, 8'd200, 1, 1'b0, POST_RST_EXP, "after_reset");

      repeat (4) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
